// File: rtl/deskew_pkg.sv
// deskew_pkg: shared state encoding, default geometry and packed-delay slicing for deskew_ctrl.
package deskew_pkg;
  localparam int N_LANES_DEF  = 20;
  localparam int MAX_SKEW_DEF = 16;
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_COUNT, S_SET, S_DONE, S_INVALID} state_t;
  function automatic int lane_lsb(input int lane, input int nb);
    return lane * nb;
  endfunction
endpackage

// File: rtl/lane_stamp_reg.sv
// lane_stamp_reg: per-lane arrival flag and AM timestamp, plus delay relative to the latest stamp.
module lane_stamp_reg #(
  parameter int NB = 4
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_stamp_req,
  input  logic [NB-1:0] i_stamp,
  output logic          o_arrived_next,
  output logic [NB-1:0] o_delay
);
  logic          r_arrived;
  logic [NB-1:0] r_stamp;
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_arrived <= 1'b0;
      r_stamp   <= '0;
    end else if (i_stamp_req && !r_arrived) begin
      r_arrived <= 1'b1;
      r_stamp   <= i_stamp;
    end
  end
  assign o_arrived_next = r_arrived | i_stamp_req;
  // A lane stamped in this very cycle is the latest arrival, so its delay is zero.
  assign o_delay = r_arrived ? i_stamp - r_stamp : '0;
endmodule

// File: rtl/deskew_ctrl.sv
// deskew_ctrl: timestamps per-lane AM arrivals, derives per-lane FIFO delays and loads them with a set strobe.
module deskew_ctrl
  import deskew_pkg::*;
#(
  parameter int N_LANES        = N_LANES_DEF,
  parameter int MAX_SKEW       = MAX_SKEW_DEF,
  parameter int NB_DELAY_COUNT = $clog2(MAX_SKEW)
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_valid,
  input  logic [N_LANES-1:0]                  i_am_lock,
  input  logic [N_LANES-1:0]                  i_start_of_lane,
  output logic [N_LANES-1:0]                  o_set_fifo_delay,
  output logic [N_LANES*NB_DELAY_COUNT-1:0]   o_read_addr,
  output logic                                o_deskew_done,
  output logic                                o_invalid_skew
);
  localparam int NB = NB_DELAY_COUNT;
  state_t                  r_state, w_next;
  logic [NB-1:0]           r_count;
  logic [N_LANES-1:0]      r_set;
  logic [N_LANES*NB-1:0]   r_read_addr;
  logic                    r_done, r_invalid;
  logic [N_LANES-1:0]      w_arrived_next;
  logic [N_LANES*NB-1:0]   w_delay;
  logic                    w_lock_all, w_hunt, w_any_start, w_all_arrived, w_clear, w_last;
  assign w_lock_all    = &i_am_lock;
  assign w_any_start   = |i_start_of_lane;
  assign w_hunt        = (r_state == S_ARMED || r_state == S_COUNT) && i_valid && w_lock_all;
  assign w_all_arrived = &w_arrived_next;
  assign w_clear       = r_state == S_IDLE || r_state == S_INVALID;
  assign w_last        = r_count == NB'(MAX_SKEW - 1);
  genvar g;
  generate
    for (g = 0; g < N_LANES; g++) begin : g_lane
      lane_stamp_reg #(.NB(NB)) u_lane (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_clear        (w_clear),
        .i_stamp_req    (w_hunt && i_start_of_lane[g]),
        .i_stamp        (r_count),
        .o_arrived_next (w_arrived_next[g]),
        .o_delay        (w_delay[lane_lsb(g, NB) +: NB])
      );
    end
  endgenerate
  always_comb begin
    w_next = r_state;
    if (!w_lock_all) w_next = S_IDLE;
    else begin
      unique case (r_state)
        S_IDLE:    w_next = S_ARMED;
        S_ARMED:   if (i_valid && w_any_start) w_next = w_all_arrived ? S_SET : S_COUNT;
        S_COUNT:   if (i_valid) w_next = w_all_arrived ? S_SET : (w_last ? S_INVALID : S_COUNT);
        S_SET:     if (i_valid) w_next = S_DONE;
        S_DONE:    w_next = S_DONE;
        S_INVALID: w_next = S_ARMED;
        default:   w_next = S_IDLE;
      endcase
    end
  end
  // ARMED holds the counter at 0, so the first arrival increments it to 1.
  always_ff @(posedge i_clock) begin
    if (i_reset || w_clear) r_count <= '0;
    else if (w_hunt && (r_state == S_COUNT || w_any_start) && !w_last) r_count <= r_count + NB'(1);
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_set       <= '0;
      r_read_addr <= '0;
      r_done      <= 1'b0;
      r_invalid   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_set     <= {N_LANES{w_next == S_SET}};
      r_done    <= w_next == S_DONE;
      r_invalid <= w_next == S_INVALID;
      if (w_next == S_SET && r_state != S_SET) r_read_addr <= w_delay;
    end
  end
  assign o_set_fifo_delay = r_set;
  assign o_read_addr      = r_read_addr;
  assign o_deskew_done    = r_done;
  assign o_invalid_skew   = r_invalid;
endmodule

// File: doc/deskew_ctrl.md
# deskew_ctrl

Per-lane skew measurement and delay-programming controller for the 100GbE PCS receive path. It sits directly upstream of the per-lane programmable deskew FIFOs. It timestamps each lane's alignment-marker arrival, computes how many blocks each lane must be delayed to line up with the latest lane, and loads those values into the FIFOs with a one-shot set strobe. It also reports deskew success or an out-of-range skew.

## Interface
- N_LANES, 20, number of PCS lanes
- MAX_SKEW, 16, skew window in valid blocks; maximum storable delay is MAX_SKEW-1
- NB_DELAY_COUNT, $clog2(MAX_SKEW), width of one delay value
- i_clock  in  1  single clock; all logic on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  block-valid qualifier; state only advances on valid cycles
- i_am_lock  in  N_LANES  per-lane alignment-marker lock
- i_start_of_lane  in  N_LANES  per-lane pulse: AM detected on this block
- o_set_fifo_delay  out  N_LANES  delay-load strobe to each lane FIFO
- o_read_addr  out  N_LANES*NB_DELAY_COUNT  packed per-lane delays; lane i at bits [i*NB_DELAY_COUNT +: NB_DELAY_COUNT]
- o_deskew_done  out  1  all lanes deskewed and delays loaded
- o_invalid_skew  out  1  one-cycle pulse: skew exceeded the window

## Operation
- FSM states: IDLE, ARMED, COUNT, SET, DONE, INVALID.
- IDLE: waits for &i_am_lock, then goes to ARMED.
- ARMED: on the first valid cycle with any i_start_of_lane bit set:
  - stamp those lanes with 0 and mark them arrived
  - set counter to 1
  - if all lanes have arrived, go to SET; otherwise go to COUNT
- COUNT: on each valid cycle:
  - lanes with i_start_of_lane set and not yet arrived are stamped with the current counter value and marked arrived
  - if all lanes have now arrived, go to SET
  - else if counter == MAX_SKEW-1, go to INVALID
  - else increment counter
- Entering SET from ARMED or COUNT: register o_read_addr[i] = L - stamp[i], where L is the stamp assigned in the transition cycle (the latest arrival). The subtraction is unsigned NB_DELAY_COUNT, never negative, and at most MAX_SKEW-1.
- SET: o_set_fifo_delay is all-ones. The block holds SET until a cycle with i_valid=1, then goes to DONE. The FIFO only consumes the strobe when its valid is high.
- DONE: o_deskew_done=1 and o_read_addr is held stable. The block stays here until any i_am_lock bit drops.
- INVALID: o_invalid_skew=1 for exactly one cycle. Then clear the arrived mask, stamps and counter, and go to ARMED to retry on the next AM period.
- In any state other than IDLE, any i_am_lock bit low forces IDLE next cycle. This clears the arrived mask, counter, o_deskew_done and o_set_fifo_delay. o_read_addr keeps its last value.
- Cycles with i_valid=0:
  - counter and FSM hold; SET remains in SET
  - i_start_of_lane is ignored
- Repeat i_start_of_lane on an already-arrived lane is ignored; its stamp is not overwritten.
- Lanes arriving in the same cycle receive identical stamps.

## Timing
- Reset values: o_set_fifo_delay=0, o_read_addr=0, o_deskew_done=0, o_invalid_skew=0, state=IDLE, counter=0, arrived mask=0, stamps=0.
- All outputs are registered.
- Last arrival at valid cycle t: o_read_addr is valid and o_set_fifo_delay=1 from cycle t+1. The strobe lasts until and including the first valid cycle at or after t+1. o_deskew_done rises on the cycle after that.
- Skew of exactly MAX_SKEW-1 valid blocks between first and last arrival is accepted.
- When the last lane has not arrived within that window, o_invalid_skew pulses on the cycle after the COUNT cycle with counter == MAX_SKEW-1.
- Reset mid-operation returns to reset values on the next edge, regardless of state.

## Structure
- Package deskew_pkg: FSM state encoding (localparam enum), default N_LANES and MAX_SKEW, and a lane-slice helper function for the packed o_read_addr.
- Sub-module lane_stamp_reg, instantiated once per lane with generate: holds the arrived flag and stamp, and computes the delay subtraction.
- The counter and FSM live in the top level.

## Test plan
All scenarios use N_LANES=20, MAX_SKEW=16.
- All 20 lanes pulse i_start_of_lane in the same valid cycle -> every o_read_addr slice is 0; o_set_fifo_delay=20'hFFFFF for 1 cycle; o_deskew_done=1 afterwards.
- Lane 0 at valid cycle 0, lanes 1-4 and 6-19 at cycle 1, lane 5 at cycle 3 -> delays: lane0=3, lanes 1-4 and 6-19 = 2, lane5=0.
- Lane 7 never arrives, all others at cycle 0 -> o_invalid_skew pulses once after 15 COUNT cycles; state returns to ARMED; o_deskew_done stays 0.
- Lane 0 at cycle 0 and lane 19 at exactly valid cycle 15 (others at 0) -> accepted: lane19=0, all other lanes=15, no invalid pulse.
- i_valid toggles 1/0 during COUNT; lane 3 arrives on the 4th valid cycle, others on the 1st -> stamps count valid cycles only (lane3 stamp 3, delays 3 for others, 0 for lane3). Duplicate pulses on lane 0 are ignored.
- In DONE, drop i_am_lock[12] -> next cycle IDLE, o_deskew_done=0. Separately, assert i_reset mid-COUNT -> all outputs 0 next cycle.
